// File: rtl/dcache_pkg.sv
// Shared types and constants for the N-way dcache storage array.
// Optional statistics counters are enabled by defining DCACHE_STATS_EN.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } flush_state_e;

  localparam int unsigned DEF_SETS   = 16;
  localparam int unsigned DEF_WAYS   = 2;
  localparam int unsigned DEF_TAG_W  = 23;
  localparam int unsigned DEF_LINE_W = 256;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned clog2w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_lru_age.sv
// True-LRU age logic for one set: victim selection and age update for a touched way.
module dcache_lru_age
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS  = DEF_WAYS,
  parameter int unsigned AGE_W = clog2w(WAYS)
) (
  input  logic [WAYS-1:0][AGE_W-1:0] age,
  input  logic [WAYS-1:0]            valid,
  input  logic [AGE_W-1:0]           touch,
  output logic [AGE_W-1:0]           victim,
  output logic [WAYS-1:0][AGE_W-1:0] age_next
);

  logic found;

  // Victim: lowest invalid way, otherwise the oldest way.
  always_comb begin
    found  = 1'b0;
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid[w]) begin
        found  = 1'b1;
        victim = AGE_W'(w);
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age[w] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
      end
    end
  end

  // Touched way becomes youngest; younger ways than it age by one.
  always_comb begin
    age_next = age;
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == touch)        age_next[w] = '0;
      else if (age[w] < age[touch])  age_next[w] = age[w] + AGE_W'(1);
    end
  end

endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache storage with true-LRU and a dirty-line flush engine.
// Define DCACHE_STATS_EN to add saturating hit/miss counters.
module dcache_sram_nway
  import dcache_pkg::*;
#(
  parameter int unsigned SETS   = DEF_SETS,
  parameter int unsigned WAYS   = DEF_WAYS,
  parameter int unsigned TAG_W  = DEF_TAG_W,
  parameter int unsigned LINE_W = DEF_LINE_W,
  localparam int unsigned IDX_W = clog2w(SETS),
  localparam int unsigned AGE_W = clog2w(WAYS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              dirty_i,
  output logic              hit_o,
  output logic [LINE_W-1:0] data_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              dirty_o,
  input  logic              flush_i,
  output logic              flush_busy_o,
  output logic              flush_done_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [IDX_W-1:0]  wb_idx_o,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [LINE_W-1:0] wb_data_o
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  logic [TAG_W-1:0]            tag_q   [SETS][WAYS];
  logic [LINE_W-1:0]           data_q  [SETS][WAYS];
  logic [WAYS-1:0]             valid_q [SETS];
  logic [WAYS-1:0]             dirty_q [SETS];
  logic [WAYS-1:0][AGE_W-1:0]  age_q   [SETS];

  flush_state_e     state_q, state_d;
  logic [IDX_W-1:0] ptr_set_q, ptr_set_d;
  logic [AGE_W-1:0] ptr_way_q, ptr_way_d;

  logic             access, hit_found, ptr_last, ptr_dirty;
  logic [AGE_W-1:0] hit_way, victim, touch, sel_way;
  logic [WAYS-1:0][AGE_W-1:0] age_next;

  assign access = enable_i && (state_q == ST_IDLE);

  // Hit search: lowest-index valid way with a matching tag.
  always_comb begin
    hit_found = 1'b0;
    hit_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_found && valid_q[idx_i][w] && (tag_q[idx_i][w] == tag_i)) begin
        hit_found = 1'b1;
        hit_way   = AGE_W'(w);
      end
    end
  end

  dcache_lru_age #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
    .age      (age_q[idx_i]),
    .valid    (valid_q[idx_i]),
    .touch    (touch),
    .victim   (victim),
    .age_next (age_next)
  );

  assign touch   = hit_found ? hit_way : victim;
  assign sel_way = touch;

  // Lookup outputs, forced to zero when idle-access is not possible.
  always_comb begin
    hit_o   = 1'b0;
    data_o  = '0;
    tag_o   = '0;
    dirty_o = 1'b0;
    if (access) begin
      hit_o   = hit_found;
      data_o  = data_q[idx_i][sel_way];
      tag_o   = hit_found ? tag_i : tag_q[idx_i][sel_way];
      dirty_o = dirty_q[idx_i][sel_way] && (hit_found || valid_q[idx_i][sel_way]);
    end
  end

  // Array state: access writes/fills, LRU update, and write-back dirty clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= '0;
          age_q[s][w]  <= AGE_W'(w);
        end
      end
    end else begin
      if (access && write_i) begin
        tag_q[idx_i][touch]   <= tag_i;
        data_q[idx_i][touch]  <= data_i;
        valid_q[idx_i][touch] <= 1'b1;
        dirty_q[idx_i][touch] <= dirty_i;
      end
      if (access && (hit_found || write_i)) age_q[idx_i] <= age_next;
      if ((state_q == ST_EMIT) && wb_ready_i) dirty_q[ptr_set_q][ptr_way_q] <= 1'b0;
    end
  end

  assign ptr_last  = (ptr_set_q == IDX_W'(SETS - 1)) && (ptr_way_q == AGE_W'(WAYS - 1));
  assign ptr_dirty = valid_q[ptr_set_q][ptr_way_q] && dirty_q[ptr_set_q][ptr_way_q];

  // Flush FSM state and pointer register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ptr_set_q <= '0;
      ptr_way_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_set_q <= ptr_set_d;
      ptr_way_q <= ptr_way_d;
    end
  end

  // Flush FSM next state: walk (set,way) in order, stopping on dirty lines.
  always_comb begin
    state_d   = state_q;
    ptr_set_d = ptr_set_q;
    ptr_way_d = ptr_way_q;
    case (state_q)
      ST_IDLE: if (flush_i) begin
        state_d   = ST_SCAN;
        ptr_set_d = '0;
        ptr_way_d = '0;
      end
      ST_SCAN: begin
        if (ptr_dirty)     state_d = ST_EMIT;
        else if (ptr_last) state_d = ST_DONE;
        else begin
          ptr_way_d = ptr_way_q + AGE_W'(1);
          if (ptr_way_q == AGE_W'(WAYS - 1)) ptr_set_d = ptr_set_q + IDX_W'(1);
        end
      end
      ST_EMIT: if (wb_ready_i) begin
        if (ptr_last) state_d = ST_DONE;
        else begin
          state_d   = ST_SCAN;
          ptr_way_d = ptr_way_q + AGE_W'(1);
          if (ptr_way_q == AGE_W'(WAYS - 1)) ptr_set_d = ptr_set_q + IDX_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign flush_busy_o = (state_q != ST_IDLE);
  assign flush_done_o = (state_q == ST_DONE);
  assign wb_valid_o   = (state_q == ST_EMIT);
  assign wb_idx_o     = wb_valid_o ? ptr_set_q : '0;
  assign wb_tag_o     = wb_valid_o ? tag_q[ptr_set_q][ptr_way_q] : '0;
  assign wb_data_o    = wb_valid_o ? data_q[ptr_set_q][ptr_way_q] : '0;

`ifdef DCACHE_STATS_EN
  // Saturating hit and miss-fill counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit_o && (hit_cnt_o != '1)) hit_cnt_o <= hit_cnt_o + 32'd1;
      if (access && write_i && !hit_found && (miss_cnt_o != '1)) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed testbench for dcache_sram_nway (default parameters, stats disabled).
module tb_dcache_sram_nway;

  localparam int unsigned SETS   = 16;
  localparam int unsigned WAYS   = 2;
  localparam int unsigned TAG_W  = 23;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned IDX_W  = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              enable_i, write_i, dirty_i, flush_i, wb_ready_i;
  logic [IDX_W-1:0]  idx_i;
  logic [TAG_W-1:0]  tag_i;
  logic [LINE_W-1:0] data_i;
  logic              hit_o, dirty_o, flush_busy_o, flush_done_o, wb_valid_o;
  logic [LINE_W-1:0] data_o, wb_data_o;
  logic [TAG_W-1:0]  tag_o, wb_tag_o;
  logic [IDX_W-1:0]  wb_idx_o;

  int n_vec = 0;
  int n_err = 0;

  dcache_sram_nway dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i),
    .idx_i(idx_i), .tag_i(tag_i), .data_i(data_i), .dirty_i(dirty_i),
    .hit_o(hit_o), .data_o(data_o), .tag_o(tag_o), .dirty_o(dirty_o),
    .flush_i(flush_i), .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_idx_o(wb_idx_o),
    .wb_tag_o(wb_tag_o), .wb_data_o(wb_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic wr, input int idx, input logic [TAG_W-1:0] tag,
                     input logic [LINE_W-1:0] d, input logic dty);
    enable_i = 1'b1;
    write_i  = wr;
    idx_i    = IDX_W'(idx);
    tag_i    = tag;
    data_i   = d;
    dirty_i  = dty;
    #1;
  endtask

  task automatic commit();
    step();
    enable_i = 1'b0;
    write_i  = 1'b0;
    #1;
  endtask

  task automatic wait_wb(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (wb_valid_o) seen = 1'b1;
      else step();
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (flush_done_o) seen = 1'b1;
      else step();
    end
  endtask

  logic [LINE_W-1:0] d_a5, d_d3, d_11, d_22, d_33, d_c1, d_90, d_9f, d_2a;
  bit seen;
  int cyc;
  bit saw_wb;

  initial begin
    d_a5 = {32{8'hA5}}; d_d3 = {32{8'hD3}}; d_11 = {32{8'h11}}; d_22 = {32{8'h22}};
    d_33 = {32{8'h33}}; d_c1 = {32{8'hC1}}; d_90 = {32{8'h90}}; d_9f = {32{8'h9F}};
    d_2a = {32{8'h2A}};
    rst_i = 1'b1; enable_i = 1'b0; write_i = 1'b0; dirty_i = 1'b0; flush_i = 1'b0;
    wb_ready_i = 1'b0; idx_i = '0; tag_i = '0; data_i = '0;
    step(); step();
    rst_i = 1'b0;
    #1;

    // Reset state
    check("rst_hit", hit_o, 0);
    check("rst_busy", flush_busy_o, 0);
    check("rst_wbv", wb_valid_o, 0);
    check("rst_done", flush_done_o, 0);

    // Cold miss in set 3: victim way0, empty
    req(0, 3, 23'h1AB, '0, 0);
    check("cold_hit", hit_o, 0);
    check("cold_tag", tag_o, 0);
    check("cold_dirty", dirty_o, 0);
    check("cold_data", data_o, 0);
    commit();

    // Fill then read back
    req(1, 3, 23'h1AB, d_a5, 0); commit();
    req(0, 3, 23'h1AB, '0, 0);
    check("fill_hit", hit_o, 1);
    check("fill_data", data_o, d_a5);
    check("fill_tag", tag_o, 23'h1AB);
    check("fill_dirty", dirty_o, 0);
    commit();

    // LRU replacement in set 5
    req(1, 5, 23'h10, d_11, 0); commit();
    req(1, 5, 23'h20, d_22, 0); commit();
    req(0, 5, 23'h10, '0, 0);
    check("lru_hit10", hit_o, 1);
    commit();
    req(0, 5, 23'h30, '0, 0);
    check("lru_miss30", hit_o, 0);
    check("lru_victag", tag_o, 23'h20);
    check("lru_vicdata", data_o, d_22);
    commit();
    req(1, 5, 23'h30, d_d3, 0); commit();
    req(0, 5, 23'h20, '0, 0);
    check("lru_evict20", hit_o, 0);
    commit();
    req(0, 5, 23'h10, '0, 0);
    check("lru_keep10", hit_o, 1);
    check("lru_data10", data_o, d_11);
    commit();
    req(0, 5, 23'h30, '0, 0);
    check("lru_hit30", hit_o, 1);
    check("lru_data30", data_o, d_d3);
    commit();

    // Dirty victim in set 0
    req(1, 0, 23'h40, d_11, 0); commit();
    req(1, 0, 23'h41, d_33, 0); commit();
    req(1, 0, 23'h40, d_22, 1); commit();
    req(0, 0, 23'h41, '0, 0); commit();
    req(0, 0, 23'h50, '0, 0);
    check("dv_hit", hit_o, 0);
    check("dv_tag", tag_o, 23'h40);
    check("dv_dirty", dirty_o, 1);
    check("dv_data", data_o, d_22);
    commit();
    req(1, 0, 23'h40, d_22, 0); commit();

    // Two dirty lines: set 1 way0, set 9 way1
    req(1, 1, 23'h61, d_c1, 1); commit();
    req(1, 9, 23'h90, d_90, 0); commit();
    req(1, 9, 23'h99, d_9f, 1); commit();

    flush_i = 1'b1; step(); flush_i = 1'b0;
    check("fl_busy", flush_busy_o, 1);
    wait_wb(seen);
    check("wb1_seen", seen, 1);
    check("wb1_idx", wb_idx_o, 1);
    check("wb1_tag", wb_tag_o, 23'h61);
    check("wb1_data", wb_data_o, d_c1);
    for (int k = 0; k < 3; k++) begin
      req(0, 3, 23'h1AB, '0, 0);
      check("busy_nohit", hit_o, 0);
      enable_i = 1'b0;
      step();
      check("stall_valid", wb_valid_o, 1);
      check("stall_idx", wb_idx_o, 1);
      check("stall_tag", wb_tag_o, 23'h61);
      check("stall_data", wb_data_o, d_c1);
    end
    wb_ready_i = 1'b1; step(); wb_ready_i = 1'b0;
    wait_wb(seen);
    check("wb2_seen", seen, 1);
    check("wb2_idx", wb_idx_o, 9);
    check("wb2_tag", wb_tag_o, 23'h99);
    check("wb2_data", wb_data_o, d_9f);
    wb_ready_i = 1'b1; step(); wb_ready_i = 1'b0;
    wait_done(seen);
    check("fl_done", seen, 1);
    check("fl_done_nowb", wb_valid_o, 0);
    step();
    check("fl_done_pulse", flush_done_o, 0);
    check("fl_idle", flush_busy_o, 0);

    // Flushed lines stay valid and clean
    req(0, 1, 23'h61, '0, 0);
    check("post_hit", hit_o, 1);
    check("post_clean", dirty_o, 0);
    commit();

    // Clean reflush latency
    flush_i = 1'b1; step(); flush_i = 1'b0;
    cyc = 1; saw_wb = 1'b0;
    while (!flush_done_o && cyc < 200) begin
      step();
      cyc++;
      if (wb_valid_o) saw_wb = 1'b1;
    end
    check("rf_latency", cyc, SETS * WAYS + 1);
    check("rf_no_wb", saw_wb, 0);
    step();

    // Reset during EMIT
    req(1, 2, 23'h22, d_2a, 1); commit();
    flush_i = 1'b1; step(); flush_i = 1'b0;
    wait_wb(seen);
    check("rs_seen", seen, 1);
    check("rs_idx", wb_idx_o, 2);
    rst_i = 1'b1;
    #1;
    check("rs_wbv", wb_valid_o, 0);
    check("rs_busy", flush_busy_o, 0);
    step();
    check("rs_nodone", flush_done_o, 0);
    rst_i = 1'b0;
    #1;
    check("rs_nodone2", flush_done_o, 0);
    req(0, 3, 23'h1AB, '0, 0);
    check("rs_miss3", hit_o, 0);
    req(0, 2, 23'h22, '0, 0);
    check("rs_miss2", hit_o, 0);
    check("rs_vdirty", dirty_o, 0);
    enable_i = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_sram_nway.md
Name: dcache_sram_nway

Overview:
- Parametrised N-way set-associative L1 data-cache storage array: tag, valid, dirty and line data per way, with true-LRU replacement.
- Lookup is combinational; all state updates (writes, fills, LRU) are clocked.
- Adds a flush engine that walks every line and emits dirty lines over a valid/ready write-back port.
- Sits between the dcache controller FSM and the memory interface.

Parameters:
- SETS, 16, number of sets (power of 2, ≥2); IDX_W = $clog2(SETS).
- WAYS, 2, associativity (power of 2, 2..8); AGE_W = $clog2(WAYS).
- TAG_W, 23, address tag bits (valid and dirty are stored separately, not packed).
- LINE_W, 256, cache line width in bits.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  access request from controller.
- write_i  in  1  with enable_i: write hit or miss fill this edge.
- idx_i  in  IDX_W  set index.
- tag_i  in  TAG_W  request tag.
- data_i  in  LINE_W  write/fill data.
- dirty_i  in  1  dirty value stored on write/fill.
- hit_o  out  1  request tag matches a valid way.
- data_o  out  LINE_W  hit line data; on miss, victim line data.
- tag_o  out  TAG_W  tag_i on hit; victim tag on miss.
- dirty_o  out  1  hit way dirty on hit; victim valid&dirty on miss.
- flush_i  in  1  start-flush pulse.
- flush_busy_o  out  1  flush engine active.
- flush_done_o  out  1  one-cycle pulse when flush completes.
- wb_valid_o  out  1  dirty line offered for write-back.
- wb_ready_i  in  1  write-back accepted.
- wb_idx_o  out  IDX_W  set of offered line.
- wb_tag_o  out  TAG_W  tag of offered line.
- wb_data_o  out  LINE_W  data of offered line.

Behaviour:
- Reset: all valid=0, dirty=0, tag=0, data=0. Per-set ages initialise to way index (way0 MRU). FSM=IDLE. All outputs 0.
- Lookup (combinational): hit = lowest-index way with valid && tag==tag_i.
  - Victim = lowest-index invalid way, else the way with age==WAYS-1.
  - If enable_i=0 or flush_busy_o=1: hit_o, data_o, tag_o and dirty_o are all 0.
- Clocked access (enable_i && !flush_busy_o):
  - Read hit: no data change.
  - Write hit: data <= data_i, dirty <= dirty_i.
  - Write miss: fill victim with valid=1, tag=tag_i, data=data_i, dirty=dirty_i.
  - Read miss: no state change.
- LRU, on any hit or fill, for the touched way w in set idx_i: age[w] <= 0; every way with age < old age[w] increments. Ages stay a permutation of 0..WAYS-1.
- Flush FSM:
  - IDLE: flush_i → SCAN, pointer (set,way)=(0,0). An access presented on the same edge still completes.
  - SCAN: if line valid&&dirty → EMIT; else advance the pointer. If the pointer was the last entry (SETS-1, WAYS-1) → DONE.
  - EMIT: wb_valid_o=1 and wb_* held stable until wb_ready_i. On handshake: dirty <= 0 (valid kept), advance, → SCAN, or → DONE if this was the last entry.
  - DONE: flush_done_o=1 for one cycle → IDLE.
  - flush_busy_o=1 in SCAN, EMIT and DONE. flush_i while busy is ignored. LRU is untouched by flush.
- Latency: a flush with no dirty lines takes SETS*WAYS+1 cycles from flush_i to flush_done_o.
- Reset asserted mid-flush: immediate return to IDLE with reset state; no flush_done_o pulse.

Optional Feature:
- DCACHE_STATS_EN defined: 32-bit saturating outputs hit_cnt_o and miss_cnt_o, reset to 0.
  - hit_cnt_o increments on each clocked hit access (enable_i && hit_o).
  - miss_cnt_o increments on each miss fill (enable_i && write_i && !hit_o).
- Undefined: the ports and counters do not exist.

Decomposition:
- Package dcache_pkg: flush FSM state enum (IDLE/SCAN/EMIT/DONE), default parameter constants, clog2-derived width helpers.
- Sub-module dcache_lru_age: per-set age vector in → victim way out, and updated age vector for a given touched way.

Test Plan:
- Reset, then read idx=3 tag=0x1AB → hit_o=0, victim way0, dirty_o=0.
- Fill idx=3 tag=0x1AB data=0xA5.., then read same → hit_o=1, data_o=0xA5.., tag_o=0x1AB.
- WAYS=2: fill tags 0x10, 0x20 into set 5, read 0x10, then miss on 0x30 → victim tag_o=0x20. Fill 0x30 → 0x20 evicted, 0x10 still hits.
- Write hit on set 0 with dirty_i=1, then miss in set 0 with that line as victim → dirty_o=1, victim data on data_o.
- Two dirty lines (set 1 way0, set 9 way1), flush with wb_ready_i low 3 cycles → two handshakes in that order, data stable while stalled. flush_done_o pulses; a reflush emits nothing and completes in SETS*WAYS+1 cycles.
- Assert rst_i during EMIT → wb_valid_o=0, flush_busy_o=0 immediately, no flush_done_o, all lookups miss.
